ysyx_220053_id_seq: RTL

YSYX_220053_ID_SEQ -- requirements
Module: ysyx_220053_id_seq

---
 rtl/ysyx_220053_pkg.sv | 35 +++
 rtl/ysyx_220053_hazard_unit.sv | 24 ++
 rtl/ysyx_220053_id_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ysyx_220053_pkg.sv
// Shared types and constants for the ysyx_220053 issue sequencer.
package ysyx_220053_pkg;

   // Register-file address width (rs1/rs2/rd fields).
   localparam int unsigned REG_ADDR_W = 5;

   // Instruction word width.
   localparam int unsigned INSTR_W = 32;

   // ebreak stops the core once it issues.
   localparam logic [INSTR_W-1:0] EBREAK_INSTR = 32'h00100073;

   // addi x0,x0,0 -- driven into the decoder whenever no instruction is held.
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

   // Slot occupancy state.
   typedef enum logic [1:0] {
      StEmpty,
      StValid,
      StHalt
   } id_state_e;

   function automatic logic is_ebreak(input logic [INSTR_W-1:0] instr);
      return instr == EBREAK_INSTR;
   endfunction

   function automatic logic [REG_ADDR_W-1:0] rs1_of(input logic [INSTR_W-1:0] instr);
      return instr[19:15];
   endfunction

   function automatic logic [REG_ADDR_W-1:0] rs2_of(input logic [INSTR_W-1:0] instr);
      return instr[24:20];
   endfunction

endpackage

// File: rtl/ysyx_220053_hazard_unit.sv
// Load-use hazard detect: the held instruction reads a register that a load in execute
// has not yet written. Applied to every opcode, so unused rs fields can cause a stall.
module ysyx_220053_hazard_unit
   import ysyx_220053_pkg::*;
(
   input  logic                  ex_valid_i,
   input  logic                  ex_is_load_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic [REG_ADDR_W-1:0] rs1_i,
   input  logic [REG_ADDR_W-1:0] rs2_i,
   output logic                  hazard_o
);

   logic rd_nonzero;
   logic rd_match;

   // x0 is never written, so a load targeting it can never create a dependency.
   always_comb begin
      rd_nonzero = (ex_rd_i != '0);
      rd_match   = (ex_rd_i == rs1_i) | (ex_rd_i == rs2_i);
      hazard_o   = ex_valid_i & ex_is_load_i & rd_nonzero & rd_match;
   end

endmodule

// File: rtl/ysyx_220053_id_seq.sv
// Single-slot instruction issue sequencer between fetch and decode/execute.
// Holds one instruction, stalls it on a load-use hazard, drops it on a redirect and
// stops the core for good once ebreak issues.
module ysyx_220053_id_seq
   import ysyx_220053_pkg::*;
#(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   // Fetch side
   input  logic               if_valid_i,
   output logic               if_ready_o,
   input  logic [XLEN-1:0]    if_pc_i,
   input  logic [INSTR_W-1:0] if_instr_i,
   // Issue side
   output logic               id_valid_o,
   input  logic               id_ready_i,
   output logic [XLEN-1:0]    id_pc_o,
   output logic [INSTR_W-1:0] id_instr_o,
   // Execute feedback
   input  logic               ex_valid_i,
   input  logic               ex_is_load_i,
   input  logic [4:0]         ex_rd_i,
   input  logic               flush_i,
   // Status
   output logic               halted_o,
   output logic [CNT_W-1:0]   issue_cnt_o,
   output logic [CNT_W-1:0]   stall_cnt_o
);

   id_state_e          state_q, state_d;
   logic [XLEN-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

   logic hazard;
   logic st_empty;
   logic st_valid;
   logic st_halt;
   logic id_valid;
   logic id_fire;
   logic if_ready;
   logic if_fire;
   logic stall_cycle;

   ysyx_220053_hazard_unit u_hazard_unit (
      .ex_valid_i   (ex_valid_i),
      .ex_is_load_i (ex_is_load_i),
      .ex_rd_i      (ex_rd_i),
      .rs1_i        (rs1_of(instr_q)),
      .rs2_i        (rs2_of(instr_q)),
      .hazard_o     (hazard)
   );

   // Handshake decode. flush_i overrides everything so a redirected slot never issues
   // and nothing new is accepted in the redirect cycle.
   always_comb begin
      st_empty    = (state_q == StEmpty);
      st_valid    = (state_q == StValid);
      st_halt     = (state_q == StHalt);
      id_valid    = st_valid & ~hazard & ~flush_i;
      id_fire     = id_valid & id_ready_i;
      if_ready    = ~st_halt & ~flush_i & (st_empty | id_fire);
      if_fire     = if_valid_i & if_ready;
      stall_cycle = st_valid & hazard & ~flush_i;
   end

   // Slot next-state: capture on accept, drain on issue, discard on redirect, park on ebreak.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      unique case (state_q)
         StEmpty: begin
            if (flush_i) begin
               pc_d    = '0;
               instr_d = NOP_INSTR;
            end else if (if_fire) begin
               state_d = StValid;
               pc_d    = if_pc_i;
               instr_d = if_instr_i;
            end
         end
         StValid: begin
            if (flush_i) begin
               state_d = StEmpty;
               pc_d    = '0;
               instr_d = NOP_INSTR;
            end else if (id_fire && is_ebreak(instr_q)) begin
               // Whatever fetch handed over in this cycle is dropped.
               state_d = StHalt;
               pc_d    = '0;
               instr_d = NOP_INSTR;
            end else if (if_fire) begin
               // Back-to-back: the slot refills in the cycle it issues.
               state_d = StValid;
               pc_d    = if_pc_i;
               instr_d = if_instr_i;
            end else if (id_fire) begin
               state_d = StEmpty;
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StEmpty;
            pc_d    = '0;
            instr_d = NOP_INSTR;
         end
      endcase
   end

   // Performance counters, free-running and wrapping.
   always_comb begin
      issue_cnt_d = issue_cnt_q + {{(CNT_W-1){1'b0}}, id_fire};
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall_cycle};
   end

   // State, slot and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StEmpty;
         pc_q        <= '0;
         instr_q     <= NOP_INSTR;
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         issue_cnt_q <= issue_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Output drive: the decoder sees a NOP at PC 0 unless an instruction is held.
   always_comb begin
      if_ready_o  = if_ready;
      id_valid_o  = id_valid;
      id_pc_o     = st_valid ? pc_q : '0;
      id_instr_o  = st_valid ? instr_q : NOP_INSTR;
      halted_o    = st_halt;
      issue_cnt_o = issue_cnt_q;
      stall_cnt_o = stall_cnt_q;
   end

endmodule
